// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_pkg
// Purpose  : Shared definitions for the registered arbitrating multiplexer.
//            Holds the arbitration-mode encodings and the select-width helpers.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

  localparam logic PRIO_RR    = 1'b0;  // round-robin arbitration
  localparam logic PRIO_FIXED = 1'b1;  // fixed priority, channel 0 highest

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width for n channels; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Purpose  : Combinational arbiter. Searches the request vector starting at
//            i_start (wrapping) in round-robin mode, or from index 0 in fixed
//            mode, and reports the first requester found.
// Ports    : i_req   - request vector, one bit per channel
//            i_start - round-robin search start index
//            i_mode  - PRIO_RR or PRIO_FIXED
//            o_grant - one-hot grant (all-0 when nothing requests)
//            o_idx   - encoded index of the granted channel
//            o_any   - at least one request present
// Revision : 1.0  initial release
// ============================================================================
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_start,
  input  logic             i_mode,
  output logic [N-1:0]     o_grant,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_base;
  logic [SEL_W-1:0] w_cand [N];
  logic [SEL_W-1:0] w_idx;
  logic             w_any;

  // Fixed mode is simply a round-robin search anchored at 0. An out-of-range
  // start (only possible for non-power-of-two N) is also anchored at 0.
  assign w_base = (i_mode == PRIO_FIXED || {1'b0, i_start} >= (SEL_W+1)'(N))
                  ? '0 : i_start;

  // w_cand[k] is the channel examined k-th: (base + k) mod N. The sum never
  // reaches 2N, so a single conditional subtract performs the modulo.
  generate
    for (genvar k = 0; k < N; k++) begin : g_cand
      logic [SEL_W:0] w_sum;
      assign w_sum     = {1'b0, w_base} + (SEL_W+1)'(k);
      assign w_cand[k] = (w_sum >= (SEL_W+1)'(N))
                         ? SEL_W'(w_sum - (SEL_W+1)'(N))
                         : w_sum[SEL_W-1:0];
    end
  endgenerate

  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_any && i_req[w_cand[k]]) begin
        w_any = 1'b1;
        w_idx = w_cand[k];
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_grant
      assign o_grant[i] = w_any && (w_idx == SEL_W'(i));
    end
  endgenerate

  assign o_idx = w_idx;
  assign o_any = w_any;

endmodule
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Purpose  : Registered N-channel multiplexer with valid/ready handshakes.
//            Arbitrates among valid inputs (round-robin or fixed priority) and
//            holds the winning word in a single-entry output register.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            in_valid/in_ready - per-channel handshake
//            in_data           - flattened channel words, channel 0 lowest
//            prio_mode         - 0 round-robin, 1 fixed priority
//            out_valid/out_ready, out_data, out_chan - registered output
// Revision : 1.0  initial release
// ============================================================================
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      prio_mode,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    r_ptr;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;

  logic                w_load_en;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_grant;
  logic [SEL_W-1:0]    w_idx;
  logic                w_any;
  logic [SEL_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]    w_sel_data;

  rr_grant #(
    .N (CHANNELS)
  ) u_grant (
    .i_req   (in_valid),
    .i_start (r_ptr),
    .i_mode  (prio_mode),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The register can accept a word when empty or when its word leaves now,
  // which gives full throughput with no bubble.
  assign w_load_en = !r_out_valid || out_ready;

  // Reset suppresses acceptance so no producer believes its word was taken.
  assign w_xfer   = w_load_en && w_any && !reset;
  assign in_ready = w_xfer ? w_grant : '0;

  assign w_sel_data = in_data[int'(w_idx)*WIDTH +: WIDTH];
  assign w_ptr_next = (w_idx == SEL_W'(CHANNELS-1)) ? '0 : w_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_idx;
        if (prio_mode == PRIO_RR) begin
          r_ptr <= w_ptr_next;
        end
      end else begin
        // Data and channel hold; only the valid flag drops.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Purpose  : Self-checking bench for mux_arb_reg (WIDTH=16, CHANNELS=4).
//            Table of per-cycle stimulus with expected in_ready; accepted
//            words are queued and compared when presented on the output.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_arb_reg;

  typedef struct {
    logic [3:0] v;
    logic       prio;
    logic       rdy;
    logic       rst;
    logic [3:0] exp_ir;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  chan;
  } word_t;

  logic        clk;
  logic        reset;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
  logic        prio_mode;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic [15:0] d [4];
  word_t       q [$];
  vec_t        tbl [$];
  int          n_pass;
  int          n_total;

  always_comb in_data = {d[3], d[2], d[1], d[0]};

  mux_arb_reg #(
    .WIDTH    (16),
    .CHANNELS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prio_mode (prio_mode),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic p, input logic r,
                              input logic rs, input logic [3:0] e);
    vec_t t;
    t.v = v; t.prio = p; t.rdy = r; t.rst = rs; t.exp_ir = e;
    return t;
  endfunction

  // Drive one cycle, check mid-cycle, then advance past the rising edge.
  task automatic step(input vec_t t);
    word_t w;
    in_valid  = t.v;
    prio_mode = t.prio;
    out_ready = t.rdy;
    reset     = t.rst;
    #4;
    chk("in_ready", {28'd0, in_ready}, {28'd0, t.exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, q[0].data});
      chk("out_chan", {30'd0, out_chan}, {30'd0, q[0].chan});
      if (t.rdy) void'(q.pop_front());
    end
    if (t.exp_ir != 4'd0 && !t.rst) begin
      for (int i = 0; i < 4; i++) begin
        if (t.exp_ir[i]) begin
          w.data = d[i];
          w.chan = 2'(i);
        end
      end
      q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (t.rst) q.delete();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 4; i++) d[i] = 16'h1111 * 16'(i + 1);
    reset     = 1'b1;
    in_valid  = 4'hF;
    prio_mode = 1'b0;
    out_ready = 1'b1;

    // Reset with every channel requesting.
    @(posedge clk);
    #1;
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_chan", {30'd0, out_chan}, 32'd0);

    // Round-robin rotation with all channels valid.
    for (int c = 0; c < 8; c++) tbl.push_back(mk(4'hF, 1'b0, 1'b1, 1'b0, 4'(1 << (c % 4))));
    // Fixed priority: 1 beats 3, then 3 once 1 drops.
    for (int c = 0; c < 3; c++) tbl.push_back(mk(4'hA, 1'b1, 1'b1, 1'b0, 4'h2));
    tbl.push_back(mk(4'h8, 1'b1, 1'b1, 1'b0, 4'h8));
    // Idle drains the register.
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0));
    // Pointer wrap with sparse requests: 3, 0, 3, 0.
    tbl.push_back(mk(4'h8, 1'b0, 1'b1, 1'b0, 4'h8));
    tbl.push_back(mk(4'h9, 1'b0, 1'b1, 1'b0, 4'h1));
    tbl.push_back(mk(4'h9, 1'b0, 1'b1, 1'b0, 4'h8));
    tbl.push_back(mk(4'h9, 1'b0, 1'b1, 1'b0, 4'h1));
    // Fixed mode leaves the pointer (1) alone; round-robin resumes from it.
    tbl.push_back(mk(4'hF, 1'b1, 1'b1, 1'b0, 4'h1));
    tbl.push_back(mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h2));
    tbl.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Backpressure: 0xBEEF from channel 2 (pointer is 2), held for 5 cycles.
    d[2] = 16'hBEEF;
    step(mk(4'h4, 1'b0, 1'b0, 1'b0, 4'h4));
    for (int c = 0; c < 5; c++) step(mk(4'hB, 1'b0, 1'b0, 1'b0, 4'h0));
    chk("bp_data", {16'd0, out_data}, 32'h0000BEEF);
    chk("bp_chan", {30'd0, out_chan}, 32'd2);
    // Release: drain and load channel 3 in the same cycle.
    step(mk(4'hB, 1'b0, 1'b1, 1'b0, 4'h8));
    d[2] = 16'h3333;

    // Reset mid-stream while a word is held under backpressure (pointer 2).
    step(mk(4'h2, 1'b0, 1'b1, 1'b0, 4'h2));
    step(mk(4'hF, 1'b0, 1'b0, 1'b0, 4'h0));
    step(mk(4'hF, 1'b0, 1'b0, 1'b1, 4'h0));
    chk("mid_rst_data", {16'd0, out_data}, 32'd0);
    chk("mid_rst_chan", {30'd0, out_chan}, 32'd0);
    // Pointer back at 0: channel 0 wins.
    step(mk(4'hF, 1'b0, 1'b1, 1'b0, 4'h1));
    step(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0));
    step(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
